// File: rtl/memdatos_ctrl_if.sv
// MemDatos request/response bundle: W/R strobes, address and write data in,
// READY/VALID/DOUT/ERR back to the datapath.
interface memdatos_ctrl_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          W;
   logic          R;
   logic [AW-1:0] ADDR;
   logic [DW-1:0] DIN;
   logic          READY;
   logic          VALID;
   logic [DW-1:0] DOUT;
   logic          ERR;

   modport master (
      output W, R, ADDR, DIN,
      input  READY, VALID, DOUT, ERR
   );

   modport slave (
      input  W, R, ADDR, DIN,
      output READY, VALID, DOUT, ERR
   );
endinterface

// File: rtl/memdatos_ctrl.sv
// Data-memory responder: single-word SW/LW requests through a 4-state FSM.
// Optional MEMDATOS_STATS_EN adds saturating write/read accept counters.
module memdatos_ctrl #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic              CLK,
   input  logic              RST,
   memdatos_ctrl_if.slave    bus
`ifdef MEMDATOS_STATS_EN
   ,
   output logic [15:0]       WR_CNT,
   output logic [15:0]       RD_CNT
`endif
);

   localparam int unsigned DEPTH = 2 ** AW;

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] addr_q;
   logic [DW-1:0] din_q;
   logic [DW-1:0] dout_q;
   logic          valid_q;
   logic          err_q;

   logic          acc_wr;
   logic          acc_rd;
   logic          err_d;
   logic          wr_en;
   logic          rd_en;

   always_comb begin
      state_d = state_q;
      acc_wr  = 1'b0;
      acc_rd  = 1'b0;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.W && !bus.R) begin
               acc_wr  = 1'b1;
               state_d = WRITE;
            end else if (bus.R && !bus.W) begin
               acc_rd  = 1'b1;
               state_d = READ;
            end else if (bus.W && bus.R) begin
               err_d = 1'b1;
            end
         end
         WRITE: begin
            wr_en   = 1'b1;
            state_d = IDLE;
         end
         READ: begin
            rd_en   = 1'b1;
            state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         addr_q  <= '0;
         din_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         valid_q <= rd_en;
         if (acc_wr || acc_rd) addr_q <= bus.ADDR;
         if (acc_wr) din_q <= bus.DIN;
         if (wr_en) mem[addr_q] <= din_q;
         if (rd_en) dout_q <= mem[addr_q];
      end
   end

   // READY is a pure decode of the registered state, so no input reaches it
   assign bus.READY = (state_q == IDLE);
   assign bus.VALID = valid_q;
   assign bus.ERR   = err_q;
   assign bus.DOUT  = dout_q;

`ifdef MEMDATOS_STATS_EN
   logic [15:0] wr_cnt_q;
   logic [15:0] rd_cnt_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         if (acc_wr && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 16'd1;
         if (acc_rd && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
   end

   assign WR_CNT = wr_cnt_q;
   assign RD_CNT = rd_cnt_q;
`endif

endmodule

// File: tb/tb_memdatos_ctrl.sv
// Bench for memdatos_ctrl: transaction table plus hand sequences; read data
// is checked by a scoreboard queue filled at read accept.
module tb_memdatos_ctrl;
   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   memdatos_ctrl_if #(.DW(DW), .AW(AW)) bus ();
`ifdef MEMDATOS_STATS_EN
   logic [15:0] wr_cnt, rd_cnt;
`endif

   memdatos_ctrl #(.DW(DW), .AW(AW)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
`ifdef MEMDATOS_STATS_EN
      ,
      .WR_CNT (wr_cnt),
      .RD_CNT (rd_cnt)
`endif
   );

   typedef enum int {OP_WR, OP_RD, OP_ILL} op_t;
   typedef struct {
      op_t           op;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      logic [DW-1:0] exp;
   } vec_t;

   int            nvec = 0;
   int            nerr = 0;
   logic [DW-1:0] sb[$];
   logic [DW-1:0] popped;
   vec_t          tbl[12];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard side: every VALID pulse must match the oldest pending read
   always @(posedge clk) begin
      #1;
      if (bus.VALID === 1'b1) begin
         if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_valid: got VALID=1 DOUT=%h expected no pulse", bus.DOUT);
         end else begin
            popped = sb.pop_front();
            check("read_data", bus.DOUT, popped);
         end
      end
      if (bus.VALID === 1'b1 || bus.ERR === 1'b1)
         check("valid_err_excl", {31'b0, bus.VALID & bus.ERR}, '0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus.READY !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      if (bus.READY !== 1'b1) begin
         nvec++;
         nerr++;
         $display("FAIL ready_timeout: got READY=%b expected 1 within 10 cycles", bus.READY);
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wait_ready();
      bus.W = 1'b1; bus.ADDR = a; bus.DIN = d;
      step();
      bus.W = 1'b0;
      check("wr_ready_low", {31'b0, bus.READY}, 32'd0);
      step();
      check("wr_ready_back", {31'b0, bus.READY}, 32'd1);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
      wait_ready();
      bus.R = 1'b1; bus.ADDR = a;
      sb.push_back(e);
      step();
      bus.R = 1'b0;
      check("rd_k_ready", {31'b0, bus.READY}, 32'd0);
      check("rd_k_valid", {31'b0, bus.VALID}, 32'd0);
      step();
      check("rd_k1_valid", {31'b0, bus.VALID}, 32'd1);
      check("rd_k1_ready", {31'b0, bus.READY}, 32'd0);
      step();
      check("rd_k2_valid", {31'b0, bus.VALID}, 32'd0);
      check("rd_k2_ready", {31'b0, bus.READY}, 32'd1);
   endtask

   task automatic do_illegal(input logic [AW-1:0] a);
      logic [DW-1:0] d0;
      wait_ready();
      d0 = bus.DOUT;
      bus.W = 1'b1; bus.R = 1'b1; bus.ADDR = a; bus.DIN = 32'hBAD0BAD0;
      step();
      bus.W = 1'b0; bus.R = 1'b0;
      check("ill_err", {31'b0, bus.ERR}, 32'd1);
      check("ill_ready", {31'b0, bus.READY}, 32'd1);
      check("ill_dout", bus.DOUT, d0);
      step();
      check("ill_err_clear", {31'b0, bus.ERR}, 32'd0);
   endtask

   initial begin
      tbl[0]  = '{OP_RD,  5'd7,  32'h0,        32'h0};
      tbl[1]  = '{OP_WR,  5'd3,  32'hDEADBEEF, 32'h0};
      tbl[2]  = '{OP_RD,  5'd3,  32'h0,        32'hDEADBEEF};
      tbl[3]  = '{OP_WR,  5'd0,  32'hA5A5A5A5, 32'h0};
      tbl[4]  = '{OP_WR,  5'd31, 32'h12345678, 32'h0};
      tbl[5]  = '{OP_RD,  5'd31, 32'h0,        32'h12345678};
      tbl[6]  = '{OP_RD,  5'd0,  32'h0,        32'hA5A5A5A5};
      tbl[7]  = '{OP_WR,  5'd31, 32'hFFFFFFFF, 32'h0};
      tbl[8]  = '{OP_RD,  5'd31, 32'h0,        32'hFFFFFFFF};
      tbl[9]  = '{OP_ILL, 5'd3,  32'h0,        32'h0};
      tbl[10] = '{OP_RD,  5'd3,  32'h0,        32'hDEADBEEF};
      tbl[11] = '{OP_RD,  5'd1,  32'h0,        32'h0};

      bus.W = 1'b0; bus.R = 1'b0; bus.ADDR = '0; bus.DIN = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      check("rst_ready", {31'b0, bus.READY}, 32'd1);
      check("rst_valid", {31'b0, bus.VALID}, 32'd0);
      check("rst_err",   {31'b0, bus.ERR},   32'd0);
      check("rst_dout",  bus.DOUT,           32'd0);

      for (int i = 0; i < 12; i++) begin
         case (tbl[i].op)
            OP_WR:   do_write(tbl[i].addr, tbl[i].din);
            OP_RD:   do_read(tbl[i].addr, tbl[i].exp);
            default: do_illegal(tbl[i].addr);
         endcase
      end

      // W held across the WRITE cycle must not cause an extra accept there
      wait_ready();
      bus.W = 1'b1; bus.ADDR = 5'd5; bus.DIN = 32'h1;
      step();
      check("hold_rdy_e1", {31'b0, bus.READY}, 32'd0);
      step();
      check("hold_rdy_e2", {31'b0, bus.READY}, 32'd1);
      step();
      check("hold_rdy_e3", {31'b0, bus.READY}, 32'd0);
      bus.W = 1'b0;
      step();
      check("hold_rdy_e4", {31'b0, bus.READY}, 32'd1);
      do_read(5'd5, 32'h1);
      do_write(5'd5, 32'h2);
      do_read(5'd5, 32'h2);
      do_write(5'd5, 32'h3);
      check("dout_hold_after_wr", bus.DOUT, 32'h2);
      do_read(5'd5, 32'h3);

      // Reset landing in READ: the pending response is dropped
      wait_ready();
      bus.R = 1'b1; bus.ADDR = 5'd3;
      step();
      bus.R = 1'b0;
      check("mid_rd_state", {31'b0, bus.READY}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ready", {31'b0, bus.READY}, 32'd1);
      check("mid_rst_valid", {31'b0, bus.VALID}, 32'd0);
      check("mid_rst_dout",  bus.DOUT,           32'd0);
      step();
      rst = 1'b0;
      repeat (3) step();
      check("post_rst_dout", bus.DOUT, 32'd0);
      do_read(5'd3, 32'h0);

`ifdef MEMDATOS_STATS_EN
      do_write(5'd9, 32'h9);
      do_write(5'd10, 32'hA);
      do_read(5'd9, 32'h9);
      do_read(5'd10, 32'hA);
      do_illegal(5'd9);
      check("wr_cnt", {16'b0, wr_cnt}, 32'd2);
      check("rd_cnt", {16'b0, rd_cnt}, 32'd3);
      force dut.wr_cnt_q = 16'hFFFF;
      #1;
      release dut.wr_cnt_q;
      do_write(5'd11, 32'hB);
      check("wr_cnt_sat", {16'b0, wr_cnt}, 32'h0000FFFF);
`endif

      repeat (2) step();
      check("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
